// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive paths: frame format,
// default bit timing and the receiver state encoding.
package uart_pkg;

    // Keep this in step with the transmitter so both ends change together.
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 10416;

    // One start bit, eight data bits, one stop bit.
    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = FRAME_BITS - 2;

    localparam logic [2:0] RX_IDLE      = 3'd0;
    localparam logic [2:0] RX_START     = 3'd1;
    localparam logic [2:0] RX_DATA      = 3'd2;
    localparam logic [2:0] RX_STOP      = 3'd3;
    localparam logic [2:0] RX_WAIT_IDLE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = RX_IDLE,
        ST_START     = RX_START,
        ST_DATA      = RX_DATA,
        ST_STOP      = RX_STOP,
        ST_WAIT_IDLE = RX_WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is
// chosen per input so an idle line does not look active after reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic UART_CLK,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments let meta and q shift as a true pipeline;
    // blocking ones here would collapse the two stages into one.
    always_ff @(posedge UART_CLK) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first: finds the start edge, samples each bit at its
// centre and reports a good byte or a framing error as a one-cycle pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       UART_CLK,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_IDX  = 3'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("uart_rx: CLKS_PER_BIT must lie in 4..65535");
    end

    rx_state_t   state;
    rx_state_t   next_state;
    logic        rx_s;
    logic        rx_s_d;
    logic [2:0]  primed;
    logic [15:0] clk_count;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        start_edge;
    logic        half_done;
    logic        bit_done;
    logic        stop_good;
    logic        stop_bad;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .UART_CLK (UART_CLK),
        .reset    (reset),
        .d        (rx),
        .q        (rx_s)
    );

    // The synchronizer outputs are reset values, not line samples, for the
    // first cycles after reset; primed blocks a false edge from a line held low.
    always_ff @(posedge UART_CLK) begin
        if (reset) begin
            rx_s_d <= 1'b1;
            primed <= '0;
        end else begin
            rx_s_d <= rx_s;
            primed <= {primed[1:0], 1'b1};
        end
    end

    assign start_edge = primed[2] && !rx_s && rx_s_d;
    assign half_done  = (clk_count == HALF_LAST);
    assign bit_done   = (clk_count == BIT_LAST);

    always_ff @(posedge UART_CLK) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state takes its default before the case, so every path through
    // this block assigns it and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (start_edge) next_state = ST_START;
            ST_START:     if (half_done)  next_state = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:      if (bit_done && bit_idx == LAST_IDX) next_state = ST_STOP;
            ST_STOP:      if (bit_done)   next_state = rx_s ? ST_IDLE : ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (rx_s)       next_state = ST_IDLE;
            default:                      next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_busy   = (state != ST_IDLE);
        stop_good = (state == ST_STOP) && bit_done && rx_s;
        stop_bad  = (state == ST_STOP) && bit_done && !rx_s;
    end

    always_ff @(posedge UART_CLK) begin
        if (reset) begin
            clk_count <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= stop_good;
            frame_err <= stop_bad;
            if (stop_good) begin
                rx_data <= shift;
            end
            case (state)
                ST_START: begin
                    clk_count <= half_done ? 16'd0 : clk_count + 16'd1;
                    bit_idx   <= '0;
                end
                ST_DATA: begin
                    if (bit_done) begin
                        clk_count      <= '0;
                        shift[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                    end else begin
                        clk_count <= clk_count + 16'd1;
                    end
                end
                ST_STOP: begin
                    clk_count <= bit_done ? 16'd0 : clk_count + 16'd1;
                end
                default: begin
                    clk_count <= '0;
                    bit_idx   <= '0;
                end
            endcase
        end
    end

endmodule
